// File: rtl/framing_mdio_ctrl.sv
// MDIO (clause 22) management frame controller.
// Serialises one 64-bit read or write frame per request on MDC/MDIO and
// reports completion with a single-cycle rsp_valid pulse.
// Optional feature macro: MDIO_PREAMBLE_SUPPRESS_EN adds req_nopre, which
// skips the 32-bit preamble for that request.
module framing_mdio_ctrl #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic        msoc_clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    input  logic        req_nopre,
`endif
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        o_emdc,
    output logic        o_emdio,
    output logic        oe_emdio,
    input  logic        i_emdio
);

    localparam int unsigned    DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0]  DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [5:0]     HDR_BIT  = 6'd32;
    localparam logic [5:0]     TA_BIT   = 6'd46;
    localparam logic [5:0]     DATA_BIT = 6'd48;
    localparam logic [5:0]     LAST_BIT = 6'd63;

    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [5:0]    bit_q, bit_d, bit_nxt;
    logic [31:0]   sh_q, sh_d;
    logic          wr_q, wr_d;
    logic [15:0]   rx_q, rx_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          emdc_q, emdc_d;
    logic          mdio_q, mdio_d;
    logic          oe_q, oe_d;
    logic          nopre;
    logic          drive;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign nopre = req_nopre;
`else
    assign nopre = 1'b0;
`endif

    // Frame phase for a global bit index (0..63).
    function automatic state_t frame_state(input logic [5:0] b);
        if (b < HDR_BIT)       return PRE;
        else if (b < TA_BIT)   return HDR;
        else if (b < DATA_BIT) return TA;
        else                   return DATA;
    endfunction

    // Serial value of bit b: preamble ones, then the 32-bit header/data word.
    function automatic logic frame_bit(input logic [5:0] b, input logic [31:0] sh);
        return (b < HDR_BIT) ? 1'b1 : sh[~b[4:0]];
    endfunction

    assign bit_nxt = 6'(bit_q + 6'd1);

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        wr_d        = wr_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        busy_d      = busy_q;
        ready_d     = ready_q;
        emdc_d      = emdc_q;
        mdio_d      = mdio_q;
        oe_d        = oe_q;
        drive       = wr_q || (bit_nxt < TA_BIT);
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                emdc_d  = 1'b0;
                mdio_d  = 1'b0;
                oe_d    = 1'b0;
                if (req_valid && ready_q) begin
                    sh_d    = {2'b01, req_write ? 2'b01 : 2'b10, req_phy, req_reg,
                               req_write ? 2'b10 : 2'b00,
                               req_write ? req_wdata : 16'h0000};
                    wr_d    = req_write;
                    bit_d   = nopre ? HDR_BIT : 6'd0;
                    div_d   = '0;
                    state_d = nopre ? HDR : PRE;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    oe_d    = 1'b1;
                    mdio_d  = frame_bit(bit_d, sh_d);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                if (div_q == DIV_MAX) begin
                    div_d = '0;
                    if (!emdc_q) begin
                        emdc_d = 1'b1;
                        if (!wr_q && (bit_q >= DATA_BIT)) begin
                            rx_d = {rx_q[14:0], i_emdio};
                        end
                    end else begin
                        emdc_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_d     = DONE;
                            rsp_valid_d = 1'b1;
                            mdio_d      = 1'b0;
                            oe_d        = 1'b0;
                            if (!wr_q) begin
                                rdata_d = rx_q;
                            end
                        end else begin
                            bit_d   = bit_nxt;
                            state_d = frame_state(bit_nxt);
                            oe_d    = drive;
                            mdio_d  = drive && frame_bit(bit_nxt, sh_q);
                        end
                    end
                end else begin
                    div_d = DW'(div_q + 1'b1);
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge msoc_clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            wr_q        <= 1'b0;
            rx_q        <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            emdc_q      <= 1'b0;
            mdio_q      <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            wr_q        <= wr_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            emdc_q      <= emdc_d;
            mdio_q      <= mdio_d;
            oe_q        <= oe_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign busy      = busy_q;
    assign o_emdc    = emdc_q;
    assign o_emdio   = mdio_q;
    assign oe_emdio  = oe_q;

endmodule

// File: tb/tb_framing_mdio_ctrl.sv
// Bench for framing_mdio_ctrl: three instances (CLK_DIV 2, 1, 255), directed
// transactions with a response scoreboard and a bit-level MDIO monitor.
module tb_framing_mdio_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  rv;
    logic        wr;
    logic [4:0]  phy, rg;
    logic [15:0] wd;
    logic        mdio_in;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic        nopre;
`endif
    logic [2:0]  ready, rsp, busy, emdc, emdio, oe;
    logic [15:0] rdata [3];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          lat;
        logic [15:0] rd;
    } exp_t;
    exp_t        sbq[$];
    logic [15:0] model_rd [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen
        localparam int unsigned DV = (g == 0) ? 2 : ((g == 1) ? 1 : 255);
        framing_mdio_ctrl #(.CLK_DIV(DV)) u (
            .msoc_clk (clk),
            .rstn     (rstn),
            .req_valid(rv[g]),
            .req_ready(ready[g]),
            .req_write(wr),
            .req_phy  (phy),
            .req_reg  (rg),
            .req_wdata(wd),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
            .req_nopre(nopre),
`endif
            .rsp_valid(rsp[g]),
            .rsp_rdata(rdata[g]),
            .busy     (busy[g]),
            .o_emdc   (emdc[g]),
            .o_emdio  (emdio[g]),
            .oe_emdio (oe[g]),
            .i_emdio  (mdio_in)
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request on instance u; abort_at >= 0 resets the DUT after that bit.
    task automatic txn(input int u, input int d, input logic w, input logic [4:0] p,
                       input logic [4:0] r, input logic [15:0] wdat, input logic [15:0] pw,
                       input logic np, input logic hold, input int abort_at, input int exp_wait);
        int n, cyc, rises, base, nb, hi_cyc, first_r, second_r, badchg, busyerr, rdchg, bitn, pulses;
        logic [63:0] fr, eoe, got, goe, mask;
        logic pc, pd;
        logic [15:0] prd;
        exp_t e;
        fr   = {32'hFFFF_FFFF, 2'b01, w ? 2'b01 : 2'b10, p, r, w ? 2'b10 : 2'b00, w ? wdat : 16'h0000};
        eoe  = w ? '1 : {{46{1'b1}}, 18'h0};
        base = np ? 32 : 0;
        nb   = 64 - base;
        mask = np ? 64'h0000_0000_FFFF_FFFF : '1;
        wr = w; phy = p; rg = r; wd = wdat;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        nopre = np;
`endif
        rv[u] = 1'b1;
        n = 0;
        while (ready[u] !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (exp_wait >= 0) chk("accept_wait", 64'(n), 64'(exp_wait));
        @(posedge clk); #1;
        if (!hold) rv[u] = 1'b0;
        if (abort_at < 0) begin
            if (!w) model_rd[u] = pw;
            sbq.push_back('{lat: (np ? 64 : 128) * d + 1, rd: model_rd[u]});
        end
        cyc = 1; rises = 0; hi_cyc = 0; first_r = 0; second_r = 0;
        badchg = 0; busyerr = 0; rdchg = 0;
        got = '0; goe = '0; pc = 1'b0; pd = 1'b0; prd = rdata[u];
        while (rsp[u] !== 1'b1 && cyc < 140 * d + 10 && !(abort_at >= 0 && rises > abort_at)) begin
            if (emdc[u] && !pc) begin
                got[63 - (rises + base)] = emdio[u];
                goe[63 - (rises + base)] = oe[u];
                if (rises == 0) first_r = cyc;
                if (rises == 1) second_r = cyc;
                rises++;
            end
            if (emdc[u]) hi_cyc++;
            if (emdio[u] !== pd && !(!emdc[u] && (pc || cyc == 1))) badchg++;
            if (busy[u] !== 1'b1 || ready[u] !== 1'b0) busyerr++;
            if (rdata[u] !== prd) rdchg++;
            pc = emdc[u]; pd = emdio[u];
            bitn = rises + base;
            mdio_in = (bitn >= 48 && bitn < 64) ? pw[63 - bitn] : 1'b0;
            @(posedge clk); #1; cyc++;
        end
        mdio_in = 1'b0;
        if (abort_at >= 0) begin
            rstn = 1'b0;
            @(posedge clk); #1;
            rstn = 1'b1;
            chk("abort_pins", {61'h0, emdc[u], emdio[u], oe[u]}, 64'h0);
            chk("abort_busy", 64'(busy[u]), 64'h0);
            chk("abort_rsp", 64'(rsp[u]), 64'h0);
            chk("abort_rdata", 64'(rdata[u]), 64'h0);
            chk("abort_ready", 64'(ready[u]), 64'h1);
            for (int i = 0; i < 3; i++) model_rd[i] = '0;
            pulses = 0;
            for (int i = 0; i < 300; i++) begin
                if (rsp[u] === 1'b1) pulses++;
                @(posedge clk); #1;
            end
            chk("abort_no_rsp", 64'(pulses), 64'h0);
            return;
        end
        if (sbq.size() == 0) begin
            chk("sb_empty", 64'h1, 64'h0);
            return;
        end
        e = sbq.pop_front();
        chk("rsp_latency", 64'(cyc), 64'(e.lat));
        chk("rsp_rdata", 64'(rdata[u]), 64'(e.rd));
        chk("frame_bits", got & mask, fr & mask);
        chk("frame_oe", goe & mask, eoe & mask);
        chk("mdc_rises", 64'(rises), 64'(nb));
        chk("mdc_period", 64'(second_r - first_r), 64'(2 * d));
        chk("mdc_high_cycles", 64'(hi_cyc), 64'(nb * d));
        chk("mdio_change_at_low", 64'(badchg), 64'h0);
        chk("busy_ready_in_frame", 64'(busyerr), 64'h0);
        chk("rdata_held", 64'(rdchg), 64'h0);
        chk("done_busy", 64'(busy[u]), 64'h1);
        chk("done_pins", {61'h0, emdc[u], emdio[u], oe[u]}, 64'h0);
        if (!hold) begin
            @(posedge clk); #1;
            chk("rsp_single_cycle", 64'(rsp[u]), 64'h0);
            chk("idle_busy", 64'(busy[u]), 64'h0);
            chk("idle_ready", 64'(ready[u]), 64'h1);
        end
    endtask

    initial begin
        rstn = 1'b0; rv = '0; wr = 1'b0; phy = '0; rg = '0; wd = '0; mdio_in = 1'b0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        nopre = 1'b0;
`endif
        for (int i = 0; i < 3; i++) model_rd[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("reset_ready", 64'(ready), 64'h7);
        chk("reset_rsp", 64'(rsp), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_pins", {55'h0, emdc, emdio, oe}, 64'h0);
        chk("reset_rdata", 64'(rdata[0]), 64'h0);
        @(posedge clk); #1;

        // Write phy=1 reg=0 0x1140.
        txn(0, 2, 1'b1, 5'd1, 5'd0, 16'h1140, 16'h0000, 1'b0, 1'b0, -1, 0);
        // Read phy=3 reg=2, PHY returns 0x0141.
        txn(0, 2, 1'b0, 5'd3, 5'd2, 16'h0000, 16'h0141, 1'b0, 1'b0, -1, 0);
        // req_valid held across a read then a write.
        txn(0, 2, 1'b0, 5'd5, 5'd1, 16'h0000, 16'hBEEF, 1'b0, 1'b1, -1, 0);
        txn(0, 2, 1'b1, 5'd5, 5'd9, 16'h5A5A, 16'h0000, 1'b0, 1'b0, -1, 1);
        // Reset in bit 40 of a read, then a normal read.
        txn(0, 2, 1'b0, 5'd7, 5'd4, 16'h0000, 16'h1234, 1'b0, 1'b0, 40, -1);
        txn(0, 2, 1'b0, 5'd2, 5'd3, 16'h0000, 16'hA5C3, 1'b0, 1'b0, -1, 0);
        // Divider extremes.
        txn(1, 1, 1'b1, 5'd31, 5'd31, 16'hFFFF, 16'h0000, 1'b0, 1'b0, -1, 0);
        txn(2, 255, 1'b0, 5'd10, 5'd21, 16'h0000, 16'h8001, 1'b0, 1'b0, -1, 0);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        // Preamble suppressed read.
        txn(0, 2, 1'b0, 5'd3, 5'd2, 16'h0000, 16'h0F0F, 1'b1, 1'b0, -1, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/framing_mdio_ctrl.md
FRAMING_MDIO_CTRL -- requirements
Module: framing_mdio_ctrl

Interface
REQ-001 Parameters SHALL be: CLK_DIV, 10, msoc_clk cycles per MDC half-period (legal range 1..255).
REQ-002 msoc_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 req_valid  input  1  management transaction request.
REQ-005 req_ready  output  1  high only in IDLE; a request is accepted on the edge where req_valid and req_ready are both high.
REQ-006 req_write, req_phy, req_reg, req_wdata  input  1/5/5/16  opcode (1 = write), PHY address, register address, write data; sampled only at accept.
REQ-007 rsp_valid  output  1  single-cycle completion pulse.
REQ-008 rsp_rdata  output  16  last read data; held until the next read completes.
REQ-009 busy  output  1  high from the cycle after accept through the rsp_valid cycle.
REQ-010 o_emdc, o_emdio, oe_emdio  output  1 each  MDC, MDIO out, MDIO output enable.
REQ-011 i_emdio  input  1  MDIO pad input.

Function
REQ-012 States SHALL be IDLE, PRE, HDR, TA, DATA, DONE; IDLE->PRE on accept, PRE->HDR after 32 bits, HDR->TA after 14 bits, TA->DATA after 2 bits, DATA->DONE after 16 bits, DONE->IDLE after one cycle.
REQ-013 The frame SHALL be 64 bits, MSB first: 32 ones, start 01, opcode 01 (write) or 10 (read), phy[4:0], reg[4:0], TA, data[15:0].
REQ-014 Each bit period SHALL be 2*CLK_DIV cycles: CLK_DIV cycles with o_emdc=0, then CLK_DIV cycles with o_emdc=1; bit 0 low phase starts the cycle after accept.
REQ-015 o_emdio SHALL change only at the start of a low phase.
REQ-016 Write frames: oe_emdio=1 for all 64 bits; TA driven as 10.
REQ-017 Read frames: oe_emdio=1 through HDR, 0 for TA and DATA; o_emdio=0 when not driven.
REQ-018 Read data bit SHALL be captured from i_emdio on the edge where o_emdc rises; rsp_rdata is updated in DONE.
REQ-019 rsp_valid SHALL assert exactly 128*CLK_DIV+1 cycles after the accept edge; writes leave rsp_rdata unchanged.
REQ-020 In IDLE and DONE: o_emdc=0, oe_emdio=0, o_emdio=0.
REQ-021 req_valid held during busy SHALL be ignored; the earliest next accept is the edge after DONE (back-to-back gap of one IDLE cycle).
REQ-022 Divider counter SHALL be ceil(log2(CLK_DIV+1)) bits and bit counter 6 bits; neither may wrap within a frame.

Reset
REQ-023 On a msoc_clk edge with rstn=0: state=IDLE, counters=0, o_emdc=0, o_emdio=0, oe_emdio=0, rsp_valid=0, rsp_rdata=0, busy=0; req_ready=1 in the following cycle.
REQ-024 Reset mid-frame SHALL abort the frame without a rsp_valid pulse; MDIO is released on the same edge.

Configuration
REQ-025 With MDIO_PREAMBLE_SUPPRESS_EN defined, input req_nopre (1 bit, sampled at accept) SHALL exist; req_nopre=1 skips PRE (IDLE->HDR, 32-bit frame, rsp_valid at 64*CLK_DIV+1 cycles).
REQ-026 Without MDIO_PREAMBLE_SUPPRESS_EN, req_nopre SHALL be absent and the preamble always sent.

Verification
REQ-027 CLK_DIV=2, write phy=1 reg=0 wdata=0x1140 -> MDIO bits 32x1, 0101 00001 00000 10 0001000101000000, oe_emdio=1 throughout, rsp_valid at cycle 257.
REQ-028 CLK_DIV=2, read phy=3 reg=2, PHY model drives 0x0141 -> oe_emdio=0 from bit 46, rsp_rdata=0x0141 at rsp_valid.
REQ-029 req_valid held high for two requests -> req_ready=0 while busy, second accepted on the edge after DONE, first read data retained during the following write.
REQ-030 rstn=0 at bit 40 of a read -> all outputs at reset values next cycle, no rsp_valid, rsp_rdata=0; a new request then completes normally.
REQ-031 CLK_DIV=1, 2 and 255 -> o_emdc period 2/4/510 cycles, 50% duty, 64 rising edges per frame.
REQ-032 MDIO_PREAMBLE_SUPPRESS_EN defined, req_nopre=1, CLK_DIV=2 read -> first MDIO bits 0110, rsp_valid at cycle 129.
